m1_bank_filler: RTL and testbench

Write-side scheduler for the M1 frame generator's ping-pong word memory. Up to NCH data sources request to deposit 12-bit words; a round-robin arbiter grants one at a time and writes each word sequentially into the bank the frame generator is not reading. The block tracks the generator's bank-select output and reports bank fill status, full-bank back-pressure and short (under-filled) banks.

---
 rtl/m1_bank_filler_if.sv | 28 ++
 rtl/m1_bank_filler.sv | 123 ++++++++++++
 tb/tb_m1_bank_filler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/m1_bank_filler_if.sv
// Write-request / memory-write bundle between the M1 data sources and the bank filler.
// The slave side is the filler; the master side is whoever drives requests and iSwitch.
interface m1_bank_filler_if #(
    parameter int NCH = 4,
    parameter int DW  = 12,
    parameter int AW  = 7
);
    logic              iSwitch;
    logic [NCH-1:0]    iReq;
    logic [NCH*DW-1:0] iData;
    logic [NCH-1:0]    oAck;
    logic              oWrEn;
    logic [AW:0]       oWrAddr;
    logic [DW-1:0]     oWrData;
    logic              oFull;
    logic              oShort;
    logic [AW:0]       oLastFill;

    modport master (
        output iSwitch, iReq, iData,
        input  oAck, oWrEn, oWrAddr, oWrData, oFull, oShort, oLastFill
    );

    modport slave (
        input  iSwitch, iReq, iData,
        output oAck, oWrEn, oWrAddr, oWrData, oFull, oShort, oLastFill
    );
endinterface

// File: rtl/m1_bank_filler.sv
// Round-robin write scheduler that fills the bank of the M1 ping-pong word
// memory not currently read by the frame generator, one word per three cycles.
module m1_bank_filler #(
    parameter int NCH   = 4,
    parameter int DW    = 12,
    parameter int WORDS = 128
) (
    input  logic            clk,
    input  logic            reset,
    m1_bank_filler_if.slave bus
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(NCH);
    localparam logic [AW:0]   PTR_FULL  = WORDS[AW:0];
    localparam logic [CW-1:0] LAST_INIT = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, FULL} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          sw_q, sw_d;
    logic [CW-1:0] last_q, last_d;
    logic [CW-1:0] winner_q, winner_d;
    logic [AW:0]   addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          full_q, full_d;
    logic          short_q, short_d;
    logic [AW:0]   lastfill_q, lastfill_d;

    logic          swap;
    logic          any_req;
    logic [CW-1:0] rr_pick;

    assign swap    = bus.iSwitch ^ sw_q;
    assign any_req = |bus.iReq;

    // Scan from the farthest channel to the nearest so the nearest requester after last_q wins.
    always_comb begin
        rr_pick = last_q;
        for (int k = NCH; k >= 1; k--) begin
            if (bus.iReq[CW'((int'(last_q) + k) % NCH)])
                rr_pick = CW'((int'(last_q) + k) % NCH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A swap landing in IDLE on a full bank empties it, so FULL would never see its exit swap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ptr_q == PTR_FULL && !swap) state_d = FULL;
                else if (any_req)               state_d = GRANT;
            end
            GRANT:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            FULL:    if (swap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.oAck = '0;
        if (state_q == GRANT) bus.oAck[winner_q] = 1'b1;
        bus.oWrEn = (state_q == WRITE);
    end

    assign bus.oWrAddr   = addr_q;
    assign bus.oWrData   = data_q;
    assign bus.oFull     = full_q;
    assign bus.oShort    = short_q;
    assign bus.oLastFill = lastfill_q;

    // Bank and word are fixed at GRANT; a later swap never redirects the in-flight write.
    always_comb begin
        sw_d     = bus.iSwitch;
        ptr_d    = ptr_q;
        last_d   = last_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (state_q == IDLE) winner_d = rr_pick;
        if (state_q == GRANT) begin
            addr_d = {~bus.iSwitch, swap ? {AW{1'b0}} : ptr_q[AW-1:0]};
            data_d = bus.iData[winner_q*DW +: DW];
            ptr_d  = swap ? (AW+1)'(1) : ptr_q + 1'b1;
            last_d = winner_q;
        end else if (swap) begin
            ptr_d = '0;
        end
        full_d     = (ptr_d == PTR_FULL);
        short_d    = swap && (ptr_q != PTR_FULL);
        lastfill_d = swap ? ptr_q : lastfill_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            sw_q       <= 1'b0;
            last_q     <= LAST_INIT;
            winner_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            full_q     <= 1'b0;
            short_q    <= 1'b0;
            lastfill_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            sw_q       <= sw_d;
            last_q     <= last_d;
            winner_q   <= winner_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            full_q     <= full_d;
            short_q    <= short_d;
            lastfill_q <= lastfill_d;
        end
    end
endmodule

// File: tb/tb_m1_bank_filler.sv
// Bench for m1_bank_filler: reset checks, a cycle table, directed bank-swap
// sequences and a randomized run against a word-count reference model.
module tb_m1_bank_filler;
    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int WORDS = 128;
    localparam int AW    = 7;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    m1_bank_filler_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

    m1_bank_filler #(.NCH(NCH), .DW(DW), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [NCH-1:0] req;
        logic [NCH-1:0] ack;
        logic           wren;
        logic [7:0]     addr;
        logic [DW-1:0]  data;
        logic           full;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.iReq    = '0;
        bus.iSwitch = 1'b0;
        bus.iData   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Requests one word on channel ch and checks where it is written; tog=1 flips
    // iSwitch in the ack cycle, tog=2 in the write cycle. iReq is left high.
    task automatic put_word(input int ch, input logic [DW-1:0] d, input logic [7:0] ea,
                            input int tog, input string nm);
        bit got;
        got = 0;
        bus.iData[ch*DW +: DW] = d;
        bus.iReq[ch] = 1'b1;
        for (int k = 0; k < 12 && !got; k++) begin
            if (bus.oAck[ch]) got = 1;
            else step();
        end
        check({nm, "_ack"}, bus.oAck[ch], 1'b1);
        if (!got) return;
        if (tog == 1) bus.iSwitch = ~bus.iSwitch;
        step();
        if (tog == 2) bus.iSwitch = ~bus.iSwitch;
        check({nm, "_wren"}, bus.oWrEn, 1'b1);
        check({nm, "_addr"}, bus.oWrAddr, ea);
        check({nm, "_data"}, bus.oWrData, d);
    endtask

    task automatic run_random();
        bit             pend[NCH];
        logic [DW-1:0]  dat[NCH];
        logic [NCH-1:0] req_prev, acked_prev, exp_ack;
        logic           sw_prev, swp, exp_short;
        bit             wr_pend;
        logic [7:0]     wr_addr;
        logic [DW-1:0]  wr_data;
        int             count, last, exp_lastfill, age, w, idx;

        do_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            pend[ch] = 0;
            dat[ch]  = '0;
        end
        req_prev = '0; acked_prev = '0; sw_prev = 1'b0; exp_short = 1'b0;
        wr_pend = 0; wr_addr = '0; wr_data = '0;
        count = 0; last = NCH - 1; exp_lastfill = 0; age = 0;

        for (int c = 0; c < 4000; c++) begin
            check("rand_wren", bus.oWrEn, wr_pend);
            if (wr_pend) begin
                check("rand_addr", bus.oWrAddr, wr_addr);
                check("rand_data", bus.oWrData, wr_data);
            end
            check("rand_full", bus.oFull, count == WORDS);
            check("rand_short", bus.oShort, exp_short);
            check("rand_lastfill", bus.oLastFill, exp_lastfill);
            if (bus.oAck != '0) begin
                exp_ack = '0;
                for (int k = NCH; k >= 1; k--) begin
                    if (req_prev[(last + k) % NCH]) begin
                        exp_ack = '0;
                        exp_ack[(last + k) % NCH] = 1'b1;
                    end
                end
                check("rand_winner", bus.oAck, exp_ack);
            end

            // Acked channels drop their word; idle channels may raise a new one.
            for (int ch = 0; ch < NCH; ch++) begin
                if (acked_prev[ch]) pend[ch] = 0;
                if (!pend[ch] && $urandom_range(0, 3) == 0) begin
                    pend[ch] = 1;
                    dat[ch]  = DW'($urandom);
                end
                bus.iReq[ch] = pend[ch];
                bus.iData[ch*DW +: DW] = dat[ch];
            end
            if ($urandom_range(0, (c < 2000) ? 599 : 59) == 0) bus.iSwitch = ~bus.iSwitch;

            swp     = bus.iSwitch ^ sw_prev;
            wr_pend = 0;
            exp_short = swp && (count != WORDS);
            if (swp) exp_lastfill = count;
            if (bus.oAck != '0) begin
                w = 0;
                for (int k = 0; k < NCH; k++) if (bus.oAck[k]) w = k;
                idx = swp ? 0 : count;
                check("rand_room", idx < WORDS, 1'b1);
                wr_pend = 1;
                wr_addr = {~bus.iSwitch, 7'(idx)};
                wr_data = dat[w];
                count   = idx + 1;
                last    = w;
                age     = 0;
            end else begin
                if (swp) count = 0;
                if (bus.iReq != '0 && count < WORDS) age++;
                else age = 0;
            end
            check("rand_live", age > 4, 1'b0);
            req_prev   = bus.iReq;
            acked_prev = bus.oAck;
            sw_prev    = bus.iSwitch;
            step();
        end
        bus.iReq = '0;
    endtask

    initial begin
        tbl[0]  = '{4'hF, 4'h0, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[1]  = '{4'hF, 4'h1, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[2]  = '{4'hF, 4'h0, 1'b1, 8'h80, 12'hA5A, 1'b0};
        tbl[3]  = '{4'hF, 4'h0, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[4]  = '{4'hF, 4'h2, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[5]  = '{4'hF, 4'h0, 1'b1, 8'h81, 12'h101, 1'b0};
        tbl[6]  = '{4'hF, 4'h0, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[7]  = '{4'hF, 4'h4, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[8]  = '{4'hF, 4'h0, 1'b1, 8'h82, 12'h102, 1'b0};
        tbl[9]  = '{4'hF, 4'h0, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[10] = '{4'hF, 4'h8, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[11] = '{4'hF, 4'h0, 1'b1, 8'h83, 12'h103, 1'b0};
        tbl[12] = '{4'hF, 4'h0, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[13] = '{4'h0, 4'h1, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[14] = '{4'h0, 4'h0, 1'b1, 8'h84, 12'hA5A, 1'b0};
        tbl[15] = '{4'h0, 4'h0, 1'b0, 8'h00, 12'h000, 1'b0};

        do_reset();
        check("rst_ack", bus.oAck, 0);
        check("rst_wren", bus.oWrEn, 0);
        check("rst_full", bus.oFull, 0);
        check("rst_short", bus.oShort, 0);
        check("rst_lastfill", bus.oLastFill, 0);
        check("rst_addr", bus.oWrAddr, 0);
        check("rst_data", bus.oWrData, 0);

        // Cycle table: channel 0 first after reset, then fair rotation 1,2,3,0.
        bus.iData = {12'h103, 12'h102, 12'h101, 12'hA5A};
        for (int i = 0; i < 16; i++) begin
            bus.iReq = tbl[i].req;
            check($sformatf("tbl%0d_ack", i), bus.oAck, tbl[i].ack);
            check($sformatf("tbl%0d_wren", i), bus.oWrEn, tbl[i].wren);
            check($sformatf("tbl%0d_full", i), bus.oFull, tbl[i].full);
            if (tbl[i].wren) begin
                check($sformatf("tbl%0d_addr", i), bus.oWrAddr, tbl[i].addr);
                check($sformatf("tbl%0d_data", i), bus.oWrData, tbl[i].data);
            end
            step();
        end

        // Full bank: 128 words into bank 1, then back-pressure until the swap.
        do_reset();
        for (int k = 0; k < WORDS; k++) put_word(0, DW'(k * 37 + 5), 8'(128 + k), 0, "fill");
        for (int k = 0; k < 8; k++) begin
            step();
            check("full_flag", bus.oFull, 1'b1);
            check("full_noack", bus.oAck, 0);
        end
        bus.iSwitch = 1'b1;
        step();
        check("swap_full", bus.oFull, 1'b0);
        check("swap_lastfill", bus.oLastFill, 128);
        check("swap_short", bus.oShort, 1'b0);
        put_word(0, 12'h5C3, 8'h00, 0, "swap_next");
        bus.iReq = '0;

        // Short bank: swap after 50 words.
        do_reset();
        for (int k = 0; k < 50; k++) put_word(0, DW'(k + 1), 8'(128 + k), 0, "part");
        bus.iReq = '0;
        step();
        bus.iSwitch = 1'b1;
        step();
        check("short_pulse", bus.oShort, 1'b1);
        check("short_lastfill", bus.oLastFill, 50);
        step();
        check("short_end", bus.oShort, 1'b0);
        check("short_hold", bus.oLastFill, 50);
        put_word(1, 12'h3C3, 8'h00, 0, "short_next");
        bus.iReq = '0;

        // Swap in the GRANT cycle, then in the WRITE cycle.
        do_reset();
        put_word(2, 12'h201, 8'h80, 0, "tg_a");
        put_word(2, 12'h202, 8'h81, 0, "tg_b");
        put_word(2, 12'h203, 8'h00, 1, "tg_grant");
        put_word(2, 12'h204, 8'h01, 2, "tg_write");
        put_word(2, 12'h205, 8'h80, 0, "tg_after");
        bus.iReq = '0;

        // Reset asserted while channel 1 is being granted.
        do_reset();
        put_word(0, 12'h111, 8'h80, 0, "rg_pre");
        bus.iReq = '0;
        step();
        bus.iData = {12'h444, 12'h333, 12'h222, 12'h777};
        bus.iReq  = 4'hF;
        step();
        check("rg_grant", bus.oAck, 4'h2);
        reset = 1'b0;
        #1;
        check("rg_ack", bus.oAck, 0);
        check("rg_wren", bus.oWrEn, 0);
        check("rg_full", bus.oFull, 0);
        check("rg_short", bus.oShort, 0);
        step();
        check("rg_nowrite", bus.oWrEn, 0);
        reset = 1'b1;
        step();
        check("rg_first", bus.oAck, 4'h1);
        step();
        check("rg_wren2", bus.oWrEn, 1'b1);
        check("rg_addr", bus.oWrAddr, 8'h80);
        check("rg_data", bus.oWrData, 12'h777);
        bus.iReq = '0;

        run_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
